// File: rtl/clock_rate_sequencer.sv
// -----------------------------------------------------------------------------
// clock_rate_sequencer
//
// Purpose:
//   Sequencer for the board's mod-k divider/blink datapath. A single shared
//   tick counter runs modulo one of three divisors (DIV0/DIV1/DIV2). A
//   requester picks the active divisor through a req/ack handshake. A new
//   divisor only takes effect on a rollover boundary, so tick spacing never
//   shrinks and the LED square wave never glitches.
//
// Ports:
//   clk      in   1  system clock
//   reset    in   1  synchronous, active-high reset
//   en       in   1  1 = counter runs; 0 = counter held at 0, LED held
//   sel      in   2  requested rate index 0..2; 3 is invalid
//   req      in   1  rate-change request (level, held until ack)
//   step     in   1  single-step pulse (only with SINGLE_STEP_EN defined)
//   ack      out  1  one-cycle pulse: request accepted
//   err      out  1  one-cycle pulse together with ack when sel was 3
//   busy     out  1  a rate change is waiting for the next rollover
//   cur_sel  out  2  index of the divisor currently in use
//   tick     out  1  one-cycle pulse on the last count of a period
//   led      out  1  toggles on every tick
//
// Build option:
//   SINGLE_STEP_EN  adds the `step` input; a step pulse while idle produces
//                   one tick (and LED toggle) on the following cycle.
// -----------------------------------------------------------------------------
module clock_rate_sequencer #(
  parameter int          W    = 28,
  parameter int unsigned DIV0 = 2_500_000,
  parameter int unsigned DIV1 = 25_000_000,
  parameter int unsigned DIV2 = 250_000_000
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       en,
  input  logic [1:0] sel,
  input  logic       req,
`ifdef SINGLE_STEP_EN
  input  logic       step,
`endif
  output logic       ack,
  output logic       err,
  output logic       busy,
  output logic [1:0] cur_sel,
  output logic       tick,
  output logic       led
);

  localparam logic [1:0] ST_IDLE     = 2'd0;
  localparam logic [1:0] ST_RUN      = 2'd1;
  localparam logic [1:0] ST_PEND     = 2'd2;
  localparam logic [1:0] SEL_INVALID = 2'd3;
  localparam int         NUM_RATES   = 3;

  // Terminal count of each rate, pre-truncated to the counter width so the
  // rollover compare is done entirely at width W.
  localparam logic [NUM_RATES-1:0][W-1:0] TERM_COUNT = {
    W'(DIV2 - 1), W'(DIV1 - 1), W'(DIV0 - 1)
  };

  logic [1:0]   state_reg, state_next;
  logic [W-1:0] count_reg, count_next;
  logic [1:0]   cur_sel_reg, cur_sel_next;
  logic [1:0]   pend_sel_reg, pend_sel_next;
  logic         led_reg, led_next;
  logic         ack_reg, ack_next;
  logic         err_reg, err_next;
  logic         ack_dly_reg;
  logic         armed_reg;

  logic [3:0]   term_hit;
  logic         at_term;
  logic [W-1:0] count_wrap;
  logic         run_tick;
  logic         req_take;
  logic         req_valid;

  // One comparator per rate; the active one is picked by cur_sel. Index 3
  // never holds a divisor, so it never reports a terminal count.
  genvar gi;
  generate
    for (gi = 0; gi < NUM_RATES; gi = gi + 1) begin : g_term
      assign term_hit[gi] = (count_reg == TERM_COUNT[gi]);
    end
  endgenerate
  assign term_hit[3] = 1'b0;

  assign at_term    = term_hit[cur_sel_reg];
  assign count_wrap = at_term ? '0 : count_reg + W'(1);

  // Ticks come only from a running counter; dropping en suppresses a tick
  // in the same cycle so the LED holds its level while disabled.
  assign run_tick = en && (state_reg != ST_IDLE) && at_term;

`ifdef SINGLE_STEP_EN
  logic step_tick_reg;

  // A step seen while idle and disabled turns into a single tick one cycle
  // later; the counter itself stays at 0.
  always_ff @(posedge clk) begin
    if (reset) begin
      step_tick_reg <= 1'b0;
    end else begin
      step_tick_reg <= step && !en && (state_reg == ST_IDLE);
    end
  end

  assign tick = run_tick | step_tick_reg;
`else
  assign tick = run_tick;
`endif

  // A request is taken only when:
  //  - no change is already pending,
  //  - it is not the tail of the previous request (req is blocked in the ack
  //    cycle and the one after, so a requester dropping req after seeing ack
  //    gets exactly one ack),
  //  - req has been seen low at least once since reset, so a level held
  //    across reset is not mistaken for a fresh request.
  assign req_take  = req && armed_reg && !ack_reg && !ack_dly_reg &&
                     (state_reg != ST_PEND);
  assign req_valid = req_take && (sel != SEL_INVALID);

  always_comb begin
    state_next    = state_reg;
    count_next    = count_reg;
    cur_sel_next  = cur_sel_reg;
    pend_sel_next = pend_sel_reg;
    led_next      = led_reg;
    ack_next      = req_take;
    err_next      = req_take && (sel == SEL_INVALID);

    if (tick) begin
      led_next = ~led_reg;
    end

    case (state_reg)
      ST_IDLE: begin
        // Count is parked at 0 here; when enabled, this cycle is the first
        // count of the period, so the counter advances as it enters RUN.
        if (req_valid) begin
          cur_sel_next = sel;
          count_next   = '0;
        end else if (en) begin
          count_next = count_wrap;
        end
        if (en) begin
          state_next = ST_RUN;
        end
      end

      ST_RUN: begin
        if (!en) begin
          // Nothing to wait for once the counter stops: apply directly.
          state_next = ST_IDLE;
          count_next = '0;
          if (req_valid) begin
            cur_sel_next = sel;
          end
        end else begin
          count_next = count_wrap;
          if (req_valid) begin
            pend_sel_next = sel;
            state_next    = ST_PEND;
          end
        end
      end

      ST_PEND: begin
        if (!en) begin
          cur_sel_next = pend_sel_reg;
          count_next   = '0;
          state_next   = ST_IDLE;
        end else if (run_tick) begin
          // Old period has just completed: the switch restarts the count so
          // the first tick at the new rate is a full new period away.
          cur_sel_next = pend_sel_reg;
          count_next   = '0;
          state_next   = ST_RUN;
        end else begin
          count_next = count_wrap;
        end
      end

      default: begin
        state_next = ST_IDLE;
        count_next = '0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_reg    <= ST_IDLE;
      count_reg    <= '0;
      cur_sel_reg  <= 2'd0;
      pend_sel_reg <= 2'd0;
      led_reg      <= 1'b0;
      ack_reg      <= 1'b0;
      err_reg      <= 1'b0;
      ack_dly_reg  <= 1'b0;
      armed_reg    <= 1'b0;
    end else begin
      state_reg    <= state_next;
      count_reg    <= count_next;
      cur_sel_reg  <= cur_sel_next;
      pend_sel_reg <= pend_sel_next;
      led_reg      <= led_next;
      ack_reg      <= ack_next;
      err_reg      <= err_next;
      ack_dly_reg  <= ack_reg;
      armed_reg    <= armed_reg | ~req;
    end
  end

  assign ack     = ack_reg;
  assign err     = err_reg;
  assign busy    = (state_reg == ST_PEND);
  assign cur_sel = cur_sel_reg;
  assign led     = led_reg;

endmodule

// File: tb/tb_clock_rate_sequencer.sv
// -----------------------------------------------------------------------------
// tb_clock_rate_sequencer
//
// Bench for clock_rate_sequencer with DIV0=4, DIV1=6, DIV2=10, W=4.
// Each test task pushes the ticks it expects (cycle, rate index, LED level
// during the tick) into a queue; a negedge monitor pops and compares every
// tick the DUT produces. Handshake and status outputs are compared inline.
// Inputs change 1 time unit after posedge; outputs are sampled on negedge.
// Define SINGLE_STEP_EN to include the step port and its test.
// -----------------------------------------------------------------------------
module tb_clock_rate_sequencer;

  localparam int W    = 4;
  localparam int DIV0 = 4;
  localparam int DIV1 = 6;
  localparam int DIV2 = 10;

  logic       clk = 1'b0;
  logic       reset;
  logic       en;
  logic [1:0] sel;
  logic       req;
  logic       ack;
  logic       err;
  logic       busy;
  logic [1:0] cur_sel;
  logic       tick;
  logic       led;
`ifdef SINGLE_STEP_EN
  logic       step;
`endif

  int checks = 0;
  int errors = 0;
  int cyc    = 0;

  typedef struct {
    int         cyc;
    logic [1:0] sel;
    logic       led;
  } tick_exp_t;

  tick_exp_t tick_q[$];

  clock_rate_sequencer #(
    .W    (W),
    .DIV0 (DIV0),
    .DIV1 (DIV1),
    .DIV2 (DIV2)
  ) dut (
    .clk     (clk),
    .reset   (reset),
    .en      (en),
    .sel     (sel),
    .req     (req),
`ifdef SINGLE_STEP_EN
    .step    (step),
`endif
    .ack     (ack),
    .err     (err),
    .busy    (busy),
    .cur_sel (cur_sel),
    .tick    (tick),
    .led     (led)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // Tick scoreboard
  always @(negedge clk) begin : tick_monitor
    tick_exp_t e;
    if (reset === 1'b0) begin
      if (tick_q.size() != 0 && tick_q[0].cyc < cyc) begin
        errors++;
        $display("FAIL tick_missing: no tick seen, required at cycle %0d (now %0d)",
                 tick_q[0].cyc, cyc);
        e = tick_q.pop_front();
      end
      if (tick !== 1'b0) begin
        checks++;
        if (tick_q.size() == 0) begin
          errors++;
          $display("FAIL tick_unexpected: tick=%b at cycle %0d, required no tick", tick, cyc);
        end else begin
          e = tick_q.pop_front();
          if (e.cyc != cyc || cur_sel !== e.sel || led !== e.led) begin
            errors++;
            $display("FAIL tick_event: got cycle %0d sel %0d led %b, required cycle %0d sel %0d led %b",
                     cyc, cur_sel, led, e.cyc, e.sel, e.led);
          end else begin
            $display("tick cycle %0d sel %0d led %b", cyc, cur_sel, led);
          end
        end
      end
    end
  end

  task automatic cyc_step();
    @(posedge clk);
    #1;
  endtask

  task automatic expect_tick(input int c, input logic [1:0] s, input logic l);
    tick_exp_t e;
    e.cyc = c;
    e.sel = s;
    e.led = l;
    tick_q.push_back(e);
  endtask

  task automatic test_reset();
    reset = 1'b1;
    en    = 1'b0;
    req   = 1'b0;
    sel   = 2'd0;
    cyc_step();
    cyc_step();
    @(negedge clk);
    checks++;
    if ({ack, err, busy, cur_sel, tick, led} !== 7'b0) begin
      errors++;
      $display("FAIL reset_values: {ack,err,busy,cur_sel,tick,led} got %b required 0000000",
               {ack, err, busy, cur_sel, tick, led});
    end
    $display("reset outputs %b", {ack, err, busy, cur_sel, tick, led});
    cyc_step();
    reset = 1'b0;
  endtask

  task automatic test_basic_rate();
    int c0;
    c0 = cyc;
    en = 1'b1;
    for (int j = 0; j < 5; j++) begin
      expect_tick(c0 + 3 + 4 * j, 2'd0, j[0]);
    end
    repeat (20) cyc_step();
    @(negedge clk);
    checks++;
    if ({led, cur_sel} !== 3'b1_00) begin
      errors++;
      $display("FAIL basic_end: {led,cur_sel} got %b required 100", {led, cur_sel});
    end
    checks++;
    if (tick_q.size() != 0) begin
      errors++;
      $display("FAIL basic_ticks: %0d ticks outstanding, required 0", tick_q.size());
    end
  endtask

  task automatic test_rate_switch();
    int b;
    b = cyc;
    expect_tick(b + 3,  2'd0, 1'b1);
    expect_tick(b + 13, 2'd2, 1'b0);
    expect_tick(b + 23, 2'd2, 1'b1);
    expect_tick(b + 33, 2'd2, 1'b0);
    cyc_step();
    req = 1'b1;
    sel = 2'd2;
    @(negedge clk);
    checks++;
    if ({ack, busy} !== 2'b00) begin
      errors++;
      $display("FAIL switch_req_cycle: {ack,busy} got %b required 00", {ack, busy});
    end
    cyc_step();
    @(negedge clk);
    checks++;
    if ({ack, err, busy, cur_sel} !== 5'b1_0_1_00) begin
      errors++;
      $display("FAIL switch_ack: {ack,err,busy,cur_sel} got %b required 10100",
               {ack, err, busy, cur_sel});
    end
    $display("req sel=2 ack=%b busy=%b at cycle %0d", ack, busy, cyc);
    cyc_step();
    req = 1'b0;
    sel = 2'd0;
    @(negedge clk);
    checks++;
    if ({ack, busy} !== 2'b01) begin
      errors++;
      $display("FAIL switch_pending: {ack,busy} got %b required 01", {ack, busy});
    end
    cyc_step();
    @(negedge clk);
    checks++;
    if ({busy, cur_sel} !== 3'b0_10) begin
      errors++;
      $display("FAIL switch_applied: {busy,cur_sel} got %b required 010", {busy, cur_sel});
    end
    while (cyc < b + 34) cyc_step();
    @(negedge clk);
    checks++;
    if (tick_q.size() != 0 || led !== 1'b1) begin
      errors++;
      $display("FAIL switch_end: outstanding %0d led %b, required 0 and 1", tick_q.size(), led);
    end
  endtask

  // Invalid sel, held past the ack window so the late level counts as a
  // second (also invalid) request.
  task automatic test_invalid_back_to_back();
    int b;
    b = cyc;
    expect_tick(b + 9,  2'd2, 1'b1);
    expect_tick(b + 19, 2'd2, 1'b0);
    cyc_step();
    req = 1'b1;
    sel = 2'd3;
    @(negedge clk);
    checks++;
    if (ack !== 1'b0) begin
      errors++;
      $display("FAIL invalid_req_cycle: ack got %b required 0", ack);
    end
    cyc_step();
    @(negedge clk);
    checks++;
    if ({ack, err, busy, cur_sel} !== 5'b1_1_0_10) begin
      errors++;
      $display("FAIL invalid_ack: {ack,err,busy,cur_sel} got %b required 11010",
               {ack, err, busy, cur_sel});
    end
    $display("req sel=3 ack=%b err=%b at cycle %0d", ack, err, cyc);
    for (int k = 0; k < 2; k++) begin
      cyc_step();
      @(negedge clk);
      checks++;
      if ({ack, err} !== 2'b00) begin
        errors++;
        $display("FAIL invalid_single_ack: {ack,err} got %b required 00 at cycle %0d",
                 {ack, err}, cyc);
      end
    end
    cyc_step();
    req = 1'b0;
    sel = 2'd0;
    @(negedge clk);
    checks++;
    if ({ack, err} !== 2'b11) begin
      errors++;
      $display("FAIL invalid_rerequest: {ack,err} got %b required 11", {ack, err});
    end
    cyc_step();
    @(negedge clk);
    checks++;
    if ({ack, err, cur_sel} !== 4'b0_0_10) begin
      errors++;
      $display("FAIL invalid_after: {ack,err,cur_sel} got %b required 0010", {ack, err, cur_sel});
    end
    while (cyc < b + 20) cyc_step();
    @(negedge clk);
    checks++;
    if (tick_q.size() != 0 || cur_sel !== 2'd2) begin
      errors++;
      $display("FAIL invalid_end: outstanding %0d cur_sel %0d, required 0 and 2",
               tick_q.size(), cur_sel);
    end
  endtask

  task automatic test_en_drop_pending();
    int b;
    b = cyc;
    cyc_step();
    req = 1'b1;
    sel = 2'd1;
    @(negedge clk);
    cyc_step();
    @(negedge clk);
    checks++;
    if ({ack, busy, cur_sel} !== 4'b1_1_10) begin
      errors++;
      $display("FAIL endrop_ack: {ack,busy,cur_sel} got %b required 1110", {ack, busy, cur_sel});
    end
    $display("req sel=1 ack=%b at cycle %0d", ack, cyc);
    cyc_step();
    req = 1'b0;
    sel = 2'd0;
    en  = 1'b0;
    @(negedge clk);
    cyc_step();
    @(negedge clk);
    checks++;
    if ({busy, cur_sel, led} !== 4'b0_01_1) begin
      errors++;
      $display("FAIL endrop_idle: {busy,cur_sel,led} got %b required 0011", {busy, cur_sel, led});
    end
    while (cyc < b + 8) cyc_step();
    en = 1'b1;
    expect_tick(b + 13, 2'd1, 1'b1);
    expect_tick(b + 19, 2'd1, 1'b0);
    while (cyc < b + 20) cyc_step();
    @(negedge clk);
    checks++;
    if (tick_q.size() != 0 || led !== 1'b1) begin
      errors++;
      $display("FAIL endrop_end: outstanding %0d led %b, required 0 and 1", tick_q.size(), led);
    end
  endtask

  task automatic test_reset_pending();
    int b;
    b = cyc;
    cyc_step();
    req = 1'b1;
    sel = 2'd2;
    @(negedge clk);
    cyc_step();
    @(negedge clk);
    checks++;
    if ({ack, busy} !== 2'b11) begin
      errors++;
      $display("FAIL rstpend_ack: {ack,busy} got %b required 11", {ack, busy});
    end
    cyc_step();
    reset = 1'b1;
    en    = 1'b0;
    @(negedge clk);
    cyc_step();
    reset = 1'b0;
    @(negedge clk);
    checks++;
    if ({ack, err, busy, cur_sel, led, tick} !== 7'b0) begin
      errors++;
      $display("FAIL rstpend_values: {ack,err,busy,cur_sel,led,tick} got %b required 0000000",
               {ack, err, busy, cur_sel, led, tick});
    end
    for (int k = 0; k < 3; k++) begin
      cyc_step();
      @(negedge clk);
      checks++;
      if (ack !== 1'b0) begin
        errors++;
        $display("FAIL rstpend_stale_req: ack got %b required 0 at cycle %0d", ack, cyc);
      end
    end
    cyc_step();
    req = 1'b0;
    @(negedge clk);
    cyc_step();
    req = 1'b1;
    sel = 2'd1;
    @(negedge clk);
    cyc_step();
    @(negedge clk);
    checks++;
    if ({ack, err, cur_sel} !== 4'b1_0_01) begin
      errors++;
      $display("FAIL idle_req: {ack,err,cur_sel} got %b required 1001", {ack, err, cur_sel});
    end
    $display("idle req sel=1 ack=%b cur_sel=%0d at cycle %0d", ack, cur_sel, cyc);
    cyc_step();
    req = 1'b0;
    sel = 2'd0;
    @(negedge clk);
  endtask

  // Request lands on the tick edge: the next old-rate period still runs in
  // full before the switch.
  task automatic test_tick_edge_request();
    int b;
    b = cyc;
    cyc_step();
    en = 1'b1;
    expect_tick(b + 6,  2'd1, 1'b0);
    expect_tick(b + 12, 2'd1, 1'b1);
    expect_tick(b + 16, 2'd0, 1'b0);
    expect_tick(b + 20, 2'd0, 1'b1);
    while (cyc < b + 6) cyc_step();
    req = 1'b1;
    sel = 2'd0;
    cyc_step();
    @(negedge clk);
    checks++;
    if ({ack, busy, cur_sel} !== 4'b1_1_01) begin
      errors++;
      $display("FAIL edge_ack: {ack,busy,cur_sel} got %b required 1101", {ack, busy, cur_sel});
    end
    cyc_step();
    req = 1'b0;
    while (cyc < b + 12) cyc_step();
    @(negedge clk);
    checks++;
    if ({busy, cur_sel} !== 3'b1_01) begin
      errors++;
      $display("FAIL edge_still_old: {busy,cur_sel} got %b required 101", {busy, cur_sel});
    end
    cyc_step();
    @(negedge clk);
    checks++;
    if ({busy, cur_sel} !== 3'b0_00) begin
      errors++;
      $display("FAIL edge_switched: {busy,cur_sel} got %b required 000", {busy, cur_sel});
    end
    while (cyc < b + 21) cyc_step();
    en = 1'b0;
    @(negedge clk);
    checks++;
    if (tick_q.size() != 0 || led !== 1'b0) begin
      errors++;
      $display("FAIL edge_end: outstanding %0d led %b, required 0 and 0", tick_q.size(), led);
    end
  endtask

`ifdef SINGLE_STEP_EN
  task automatic test_single_step();
    int b;
    b = cyc;
    cyc_step();
    step = 1'b1;
    expect_tick(b + 2, 2'd0, 1'b0);
    cyc_step();
    step = 1'b0;
    cyc_step();
    @(negedge clk);
    checks++;
    if (led !== 1'b1) begin
      errors++;
      $display("FAIL step_led: led got %b required 1", led);
    end
    cyc_step();
    en = 1'b1;
    expect_tick(b + 7, 2'd0, 1'b1);
    cyc_step();
    step = 1'b1;
    cyc_step();
    step = 1'b0;
    while (cyc < b + 8) cyc_step();
    en = 1'b0;
    @(negedge clk);
    checks++;
    if (tick_q.size() != 0 || led !== 1'b0) begin
      errors++;
      $display("FAIL step_end: outstanding %0d led %b, required 0 and 0", tick_q.size(), led);
    end
  endtask
`endif

  initial begin
    reset = 1'b1;
    en    = 1'b0;
    req   = 1'b0;
    sel   = 2'd0;
`ifdef SINGLE_STEP_EN
    step  = 1'b0;
`endif
    test_reset();
    test_basic_rate();
    test_rate_switch();
    test_invalid_back_to_back();
    test_en_drop_pending();
    test_reset_pending();
    test_tick_edge_request();
`ifdef SINGLE_STEP_EN
    test_single_step();
`endif
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached at cycle %0d", cyc);
    $fatal(1, "watchdog expired");
  end

endmodule
